cordic_vectoring: RTL and testbench

// Iterative CORDIC engine in vectoring mode, the inverse of the sine/cosine rotation unit.

---
 rtl/cordic_vectoring.sv | 155 +++++++++++++++
 tb/tb_cordic_vectoring.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) in Q3.28 -> magnitude and atan2(y,x).
// One micro-rotation per cycle, followed by a single gain-compensation multiply.
module cordic_vectoring #(
   parameter int WIDTH = 32,
   parameter int ITER  = 28,
   parameter int GUARD = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mag_out,
   output logic [WIDTH-1:0] angle_out
);
   localparam int DW = WIDTH + GUARD;
   localparam int IW = $clog2(ITER + 1);
   localparam logic signed [WIDTH-1:0] PI     = WIDTH'(843314857);
   localparam logic signed [63:0]      KGAIN  = 64'sd163007430;
   localparam logic signed [63:0]      MAGMAX = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;

   state_t                  state;
   logic signed [DW-1:0]    x, y;
   logic signed [WIDTH-1:0] z;
   logic [IW-1:0]           i;
   logic                    zero_vec;

   logic signed [DW-1:0]    xe, ye, x_nx, y_nx;
   logic signed [WIDTH-1:0] z_nx;
   logic signed [63:0]      prod, msc;
   logic [WIDTH-1:0]        mag_sat;

   // round(atan(2^-k) * 2^28)
   function automatic logic signed [WIDTH-1:0] atan_tab(input int k);
      logic signed [31:0] v;
      case (k)
         0:  v = 32'sd210828714;
         1:  v = 32'sd124459457;
         2:  v = 32'sd65760959;
         3:  v = 32'sd33381290;
         4:  v = 32'sd16755422;
         5:  v = 32'sd8385879;
         6:  v = 32'sd4193963;
         7:  v = 32'sd2097109;
         8:  v = 32'sd1048571;
         9:  v = 32'sd524287;
         10: v = 32'sd262144;
         11: v = 32'sd131072;
         12: v = 32'sd65536;
         13: v = 32'sd32768;
         14: v = 32'sd16384;
         15: v = 32'sd8192;
         16: v = 32'sd4096;
         17: v = 32'sd2048;
         18: v = 32'sd1024;
         19: v = 32'sd512;
         20: v = 32'sd256;
         21: v = 32'sd128;
         22: v = 32'sd64;
         23: v = 32'sd32;
         24: v = 32'sd16;
         25: v = 32'sd8;
         26: v = 32'sd4;
         27: v = 32'sd2;
         default: v = 32'sd0;
      endcase
      return WIDTH'(v);
   endfunction

   // input sign extension, one micro-rotation, and gain-compensated magnitude
   always_comb begin
      xe = {{GUARD{x_in[WIDTH-1]}}, x_in};
      ye = {{GUARD{y_in[WIDTH-1]}}, y_in};
      if (!y[DW-1]) begin
         x_nx = x + (y >>> i);
         y_nx = y - (x >>> i);
         z_nx = z + atan_tab(int'(i));
      end else begin
         x_nx = x - (y >>> i);
         y_nx = y + (x >>> i);
         z_nx = z - atan_tab(int'(i));
      end
      prod = 64'(x) * KGAIN;
      msc  = prod >>> 28;
      if (msc < 64'sd0)      mag_sat = '0;
      else if (msc > MAGMAX) mag_sat = MAGMAX[WIDTH-1:0];
      else                   mag_sat = msc[WIDTH-1:0];
   end

   // control FSM plus datapath registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         mag_out   <= '0;
         angle_out <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         i         <= '0;
         zero_vec  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  // fold left half-plane into the right so the iterations converge
                  if (x_in[WIDTH-1]) begin
                     x <= -xe;
                     y <= -ye;
                     z <= y_in[WIDTH-1] ? -PI : PI;
                  end else begin
                     x <= xe;
                     y <= ye;
                     z <= '0;
                  end
                  zero_vec <= (x_in == '0) && (y_in == '0);
                  i        <= '0;
                  in_ready <= 1'b0;
                  state    <= S_ITER;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_ITER: begin
               x <= x_nx;
               y <= y_nx;
               z <= z_nx;
               i <= i + 1'b1;
               if (i == IW'(ITER - 1)) state <= S_SCALE;
            end
            S_SCALE: begin
               mag_out   <= mag_sat;
               // a zero vector would otherwise report the summed table as its angle
               angle_out <= zero_vec ? '0 : z;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring. Expected magnitudes use K = 0.60725 exactly,
// which reads about 1299 LSB below true magnitude for a unit vector.
module tb_cordic_vectoring;
   localparam int WIDTH = 32;
   localparam int ITER  = 28;
   localparam int TOL   = 1024;
   localparam logic [31:0] MAG1 = 32'd268434157;

   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] x_in, y_in, mag_out, angle_out;

   int tests = 0;
   int fails = 0;

   cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
      .mag_out(mag_out), .angle_out(angle_out)
   );

   always #5 clk = ~clk;

   function automatic longint adiff(input logic [31:0] a, input logic [31:0] b);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      return (d < 0) ? -d : d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one vector, wait for in_ready (bounded); returns 0 on timeout
   task automatic send(input logic [31:0] xv, input logic [31:0] yv, output bit ok);
      int n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      ok = in_ready;
      in_valid = 1'b1; x_in = xv; y_in = yv;
      tick();
      in_valid = 1'b0;
   endtask

   // wait for out_valid (bounded), capture, then accept the result
   task automatic collect(output logic [31:0] m, output logic [31:0] a, output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      m = mag_out; a = angle_out;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input string nm, input logic [31:0] xv, input logic [31:0] yv,
                          output logic [31:0] m, output logic [31:0] a, output int lat);
      bit ok;
      send(xv, yv, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_accept: in_ready never rose (got %0b, want 1)", nm, in_ready);
      end
      collect(m, a, lat);
      tests++;
      if (lat >= 100) begin
         fails++;
         $display("FAIL %s_timeout: out_valid not seen in %0d cycles, want %0d", nm, lat, ITER + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
      repeat (3) tick();
      tests += 4;
      if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      if (mag_out !== '0)     begin fails++; $display("FAIL rst_mag: got %0d want 0", mag_out); end
      if (angle_out !== '0)   begin fails++; $display("FAIL rst_angle: got %0d want 0", angle_out); end
      rst_n = 1'b1;
      tick();
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [31:0] m, a; int lat;
      run_vec("unit", 32'd268435456, 32'd0, m, a, lat);
      tests += 3;
      if (lat !== ITER + 1) begin fails++; $display("FAIL unit_latency: got %0d want %0d", lat, ITER + 1); end
      if (adiff(m, MAG1) > TOL) begin fails++; $display("FAIL unit_mag: got %0d want %0d", m, MAG1); end
      if (adiff(a, 32'd0) > TOL) begin fails++; $display("FAIL unit_angle: got %0d want 0", $signed(a)); end
   endtask

   task automatic test_quadrants();
      logic [31:0] m, a; int lat;
      logic [31:0] xs [4] = '{32'd232471924, -32'sd232471924, -32'sd268435456, 32'd0};
      logic [31:0] ys [4] = '{32'd134217728, -32'sd134217728, 32'd0, -32'sd268435456};
      logic [31:0] ea [4] = '{32'd140552476, -32'sd702762380, 32'd843314857, -32'sd421657428};
      for (int k = 0; k < 4; k++) begin
         run_vec($sformatf("quad%0d", k), xs[k], ys[k], m, a, lat);
         tests += 2;
         if (adiff(a, ea[k]) > TOL) begin
            fails++; $display("FAIL quad%0d_angle: got %0d want %0d", k, $signed(a), $signed(ea[k]));
         end
         if (adiff(m, MAG1) > TOL) begin
            fails++; $display("FAIL quad%0d_mag: got %0d want %0d", k, m, MAG1);
         end
      end
   endtask

   task automatic test_boundary();
      logic [31:0] m, a; int lat;
      run_vec("zero", 32'd0, 32'd0, m, a, lat);
      tests += 2;
      if (m !== 32'd0) begin fails++; $display("FAIL zero_mag: got %0d want 0", m); end
      if (a !== 32'd0) begin fails++; $display("FAIL zero_angle: got %0d want 0", $signed(a)); end
      run_vec("sat", 32'd2144799293, 32'd2144799293, m, a, lat);
      tests += 2;
      if (m !== 32'h7FFFFFFF) begin fails++; $display("FAIL sat_mag: got %h want 7fffffff", m); end
      if (adiff(a, 32'd210828714) > TOL) begin
         fails++; $display("FAIL sat_angle: got %0d want 210828714", $signed(a));
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] m0, a0; bit ok; int n = 0; int early = 0;
      send(32'd134217728, 32'd134217728, ok);
      while (!out_valid && n < 100) begin tick(); n++; end
      tests++;
      if (!out_valid) begin fails++; $display("FAIL bp_timeout: out_valid got 0 want 1"); end
      m0 = mag_out; a0 = angle_out;
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0]; x_in = 32'd268435456; y_in = 32'd0;
         tick();
         tests++;
         if (mag_out !== m0 || angle_out !== a0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: mag %0d ang %0d ov %0b ir %0b want mag %0d ang %0d ov 1 ir 0",
                     c, mag_out, $signed(angle_out), out_valid, in_ready, m0, $signed(a0));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < ITER + 4; c++) begin
         if (out_valid) early++;
         tick();
      end
      tests++;
      if (early !== 0) begin fails++; $display("FAIL bp_no_phantom: out_valid cycles got %0d want 0", early); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] m, a; int lat; bit ok;
      send(32'd268435456, 32'd268435456, ok);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0 || mag_out !== '0 || angle_out !== '0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: ov %0b mag %0d ang %0d ir %0b want all 0",
                  out_valid, mag_out, angle_out, in_ready);
      end
      rst_n = 1'b1;
      tick();
      run_vec("post_rst", 32'd0, 32'd268435456, m, a, lat);
      tests += 2;
      if (adiff(a, 32'd421657428) > TOL) begin
         fails++; $display("FAIL post_rst_angle: got %0d want 421657428", $signed(a));
      end
      if (adiff(m, MAG1) > TOL) begin fails++; $display("FAIL post_rst_mag: got %0d want %0d", m, MAG1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_quadrants();
      test_boundary();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
